// File: rtl/gerador_palavras.sv
// gerador_palavras: command-driven burst word generator.
// A 4-bit command starts a burst of 1..4 parity-protected words, each handed
// to the consumer with a valid/ack handshake. Words are separated by a
// one-cycle gap. A consumer that stalls for 16 cycles aborts the burst.
module gerador_palavras (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       b8,
  output logic       b7,
  output logic       b6,
  output logic       b5,
  output logic       b4,
  output logic       b3,
  output logic       b2,
  output logic       b1,
  output logic       word_valid,
  input  logic       ack,
  output logic       done,
  output logic       timeout_err,
  output logic [7:0] words_sent
);

  typedef enum logic [2:0] {IDLE, SEND, GAP, DONE, ERR} state_t;

  state_t     state, state_nxt;
  logic [3:0] cmd_q;      // command latched at acceptance
  logic [1:0] k;          // index of the word being sent
  logic [3:0] wait_cnt;   // SEND cycles spent without ack
  logic       accept;
  logic       last;
  logic       timeout;
  logic [7:0] word;

  assign accept  = cmd_valid && (state == IDLE);
  assign last    = (k == cmd_q[1:0]);
  // ack on the 16th cycle takes priority over the timeout
  assign timeout = (state == SEND) && !ack && (wait_cnt == 4'hF);

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid) state_nxt = SEND;
      SEND: begin
        if (ack)                    state_nxt = last ? DONE : GAP;
        else if (wait_cnt == 4'hF)  state_nxt = ERR;
      end
      GAP:     state_nxt = SEND;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // burst datapath: latched command, word index, stall counter, flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_q       <= 4'd0;
      k           <= 2'd0;
      wait_cnt    <= 4'd0;
      timeout_err <= 1'b0;
      words_sent  <= 8'd0;
    end else begin
      if (accept) begin
        cmd_q       <= cmd;
        k           <= 2'd0;
        timeout_err <= 1'b0;
      end
      if (timeout)                 timeout_err <= 1'b1;
      if (state == GAP)            k           <= k + 2'd1;
      if ((state == SEND) && ack)  words_sent  <= words_sent + 8'd1;
      // counter is zero on every entry to SEND since it is held clear elsewhere
      if (state != SEND)           wait_cnt    <= 4'd0;
      else if (!ack)               wait_cnt    <= wait_cnt + 4'd1;
    end
  end

  // word format: first-word flag, index, even parity bit, command
  always_comb begin
    word       = 8'd0;
    word[7]    = (k == 2'd0);
    word[6:5]  = k;
    word[3:0]  = cmd_q;
    word[4]    = word[7] ^ word[6] ^ word[5] ^ (^cmd_q);
    if (state != SEND) word = 8'd0;
  end

  assign cmd_ready  = (state == IDLE);
  assign word_valid = (state == SEND);
  assign done       = (state == DONE);
  assign {b8, b7, b6, b5, b4, b3, b2, b1} = word;

endmodule
